// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity sense and legal prescale values.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int unsigned PRESCALE_8  = 8;
    localparam int unsigned PRESCALE_16 = 16;
    localparam int unsigned PRESCALE_32 = 32;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter with a 3-sample majority voter around mid-bit.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  clr,
    input  logic                  rx,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  bit_val,
    output logic                  decide,
    output logic                  bit_end
);

    logic [PRESCALE_W-1:0] edge_cnt;
    logic [PRESCALE_W-1:0] half;
    logic [PRESCALE_W-1:0] last;
    logic                  s0;
    logic                  s1;

    assign half    = prescale >> 1;
    assign last    = prescale - 1'b1;
    // >= rather than == so an out-of-range prescale still wraps the counter
    assign bit_end = en && (edge_cnt >= last);
    assign decide  = en && (edge_cnt == half + 1'b1);
    assign bit_val = maj3(s0, s1, rx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_cnt <= '0;
            s0       <= 1'b1;
            s1       <= 1'b1;
        end else begin
            if (clr || !en || bit_end)
                edge_cnt <= '0;
            else
                edge_cnt <= edge_cnt + 1'b1;
            if (en && (edge_cnt == half - 1'b1))
                s0 <= rx;
            if (en && (edge_cnt == half))
                s1 <= rx;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronized line, oversampled majority-voted bits, optional parity.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [PRESCALE_W-1:0] PRESCALE,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_VALID,
    output logic                  PAR_ERR,
    output logic                  STP_ERR,
    output logic                  Busy
);

    localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    uart_state_t           state;
    uart_state_t           state_nxt;
    logic                  rx_meta;
    logic                  rx_sync;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic [PRESCALE_W-1:0] prescale_q;
    logic [BCW-1:0]        bit_cnt;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  par_err_q;
    logic                  start_det;
    logic                  bit_val;
    logic                  decide;
    logic                  bit_end;

    assign start_det = (state == IDLE) && !rx_sync;
    assign Busy      = (state != IDLE);

    uart_rx_sampler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_sampler (
        .clk      (clk),
        .rst      (rst),
        .en       (Busy),
        .clr      (start_det),
        .rx       (rx_sync),
        .prescale (prescale_q),
        .bit_val  (bit_val),
        .decide   (decide),
        .bit_end  (bit_end)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= RX_IN;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // every non-IDLE state also exits on bit_end, so a bad prescale cannot hang the FSM
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!rx_sync) state_nxt = START;
            START: begin
                if (decide && bit_val)
                    state_nxt = IDLE;
                else if (bit_end)
                    state_nxt = DATA;
            end
            DATA: begin
                if (bit_end && (bit_cnt == BCW'(DATA_WIDTH - 1)))
                    state_nxt = par_en_q ? PARITY : STOP;
            end
            PARITY:  if (bit_end) state_nxt = STOP;
            STOP:    if (decide || bit_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            prescale_q <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            par_err_q  <= 1'b0;
            P_DATA     <= '0;
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;
        end else begin
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;
            if (start_det) begin
                par_en_q   <= PAR_EN;
                par_typ_q  <= PAR_TYP;
                prescale_q <= PRESCALE;
                bit_cnt    <= '0;
                par_err_q  <= 1'b0;
            end
            if (state == DATA && decide)
                shift_reg <= {bit_val, shift_reg[DATA_WIDTH-1:1]};
            if (state == DATA && bit_end)
                bit_cnt <= bit_cnt + 1'b1;
            if (state == PARITY && decide)
                par_err_q <= bit_val != ((^shift_reg) ^ par_typ_q);
            if (state == STOP && decide) begin
                STP_ERR <= !bit_val;
                PAR_ERR <= par_err_q;
                if (bit_val && !par_err_q) begin
                    DATA_VALID <= 1'b1;
                    P_DATA     <= shift_reg;
                end
            end
        end
    end

endmodule
